inst_decode_stage: RTL and testbench

- Registered decode stage directly downstream of the instruction fetch/ROM stage.
- Captures the 32-bit MIPS instruction word the fetch stage produces, splits it into fields, and generates main control signals for execute.
- One pipeline register (IF/ID) with stall/flush control, plus a saturating retired-decode counter for debug.

---
 rtl/inst_decode_stage.sv | 190 +++++++++++++++++++
 tb/tb_inst_decode_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// IF/ID decode stage: registers the fetched MIPS word, splits it into fields and
// produces the main execute controls, with flush/stall and a saturating decode counter.
module inst_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_code,
    input  logic             inst_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             id_valid,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [31:0]      imm_ext,
    output logic [25:0]      jaddr,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B, OP_BEQ = 6'h04,
                           OP_BNE   = 6'h05, OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_SLT = 6'h2A, FN_SLL = 6'h00, FN_SRL = 6'h02;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [25:0] jaddr;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    dec_t             dec_d;
    dec_t             dec_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      imm16;
    logic [4:0]       dest;

    assign imm16 = inst_code[15:0];

    always_comb begin
        dec_d         = '0;
        dec_d.opcode  = inst_code[31:26];
        dec_d.rs      = inst_code[25:21];
        dec_d.rt      = inst_code[20:16];
        dec_d.rd      = inst_code[15:11];
        dec_d.shamt   = inst_code[10:6];
        dec_d.funct   = inst_code[5:0];
        dec_d.jaddr   = inst_code[25:0];
        dec_d.imm_ext = {{16{imm16[15]}}, imm16};

        case (inst_code[31:26])
            OP_RTYPE: begin
                dec_d.reg_dst   = 1'b1;
                dec_d.reg_write = 1'b1;
                case (inst_code[5:0])
                    FN_ADD:  dec_d.alu_op = ALU_ADD;
                    FN_SUB:  dec_d.alu_op = ALU_SUB;
                    FN_AND:  dec_d.alu_op = ALU_AND;
                    FN_OR:   dec_d.alu_op = ALU_OR;
                    FN_SLT:  dec_d.alu_op = ALU_SLT;
                    FN_SLL:  dec_d.alu_op = ALU_SLL;
                    FN_SRL:  dec_d.alu_op = ALU_SRL;
                    default: dec_d.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_d.alu_op    = ALU_AND;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.imm_ext   = {16'h0, imm16};
            end
            OP_ORI: begin
                dec_d.alu_op    = ALU_OR;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.imm_ext   = {16'h0, imm16};
            end
            OP_LUI: begin
                dec_d.alu_op    = ALU_LUI;
                dec_d.alu_src   = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.imm_ext   = {imm16, 16'h0};
            end
            OP_LW: begin
                dec_d.alu_src   = 1'b1;
                dec_d.mem_read  = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OP_SW: begin
                dec_d.alu_src   = 1'b1;
                dec_d.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_d.alu_op = ALU_SUB;
                dec_d.branch = 1'b1;
            end
            OP_J:    dec_d.jump    = 1'b1;
            default: dec_d.illegal = 1'b1;
        endcase

        // An illegal word keeps its fields but must not drive any execute control.
        if (dec_d.illegal) begin
            dec_d.alu_op    = ALU_ADD;
            dec_d.reg_dst   = 1'b0;
            dec_d.reg_write = 1'b0;
        end

        dest = dec_d.reg_dst ? dec_d.rd : dec_d.rt;
        if (dest == 5'd0)
            dec_d.reg_write = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_q <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else if (flush) begin
            dec_q <= '0;
            vld_q <= 1'b0;
        end else if (!stall) begin
            if (inst_valid) begin
                dec_q <= dec_d;
                vld_q <= 1'b1;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                dec_q <= '0;
                vld_q <= 1'b0;
            end
        end
    end

    assign id_valid  = vld_q;
    assign opcode    = dec_q.opcode;
    assign rs        = dec_q.rs;
    assign rt        = dec_q.rt;
    assign rd        = dec_q.rd;
    assign shamt     = dec_q.shamt;
    assign funct     = dec_q.funct;
    assign imm_ext   = dec_q.imm_ext;
    assign jaddr     = dec_q.jaddr;
    assign alu_op    = dec_q.alu_op;
    assign reg_write = dec_q.reg_write;
    assign reg_dst   = dec_q.reg_dst;
    assign alu_src   = dec_q.alu_src;
    assign mem_read  = dec_q.mem_read;
    assign mem_write = dec_q.mem_write;
    assign branch    = dec_q.branch;
    assign jump      = dec_q.jump;
    assign illegal   = dec_q.illegal;
    assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed steps plus random traffic against a table-driven
// reference; a second instance with a 4-bit counter covers saturation.
module tb_inst_decode_stage;

    logic        clk, rst;
    logic [31:0] inst_code;
    logic        inst_valid, stall, flush;

    logic        id_valid, reg_write, reg_dst, alu_src, mem_read, mem_write, branch, jump, illegal;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
    logic [3:0]  alu_op;
    logic [15:0] inst_cnt;

    logic        v4, rw4, rdst4, as4, mr4, mw4, br4, jp4, il4;
    logic [5:0]  op4, fn4;
    logic [4:0]  rs4, rt4, rd4, sh4;
    logic [31:0] imm4;
    logic [25:0] ja4;
    logic [3:0]  alu4;
    logic [3:0]  cnt4;

    inst_decode_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .inst_code(inst_code), .inst_valid(inst_valid),
        .stall(stall), .flush(flush), .id_valid(id_valid), .opcode(opcode), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm_ext(imm_ext), .jaddr(jaddr),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .illegal(illegal), .inst_cnt(inst_cnt)
    );

    inst_decode_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .inst_code(inst_code), .inst_valid(inst_valid),
        .stall(stall), .flush(flush), .id_valid(v4), .opcode(op4), .rs(rs4),
        .rt(rt4), .rd(rd4), .shamt(sh4), .funct(fn4), .imm_ext(imm4), .jaddr(ja4),
        .alu_op(alu4), .reg_write(rw4), .reg_dst(rdst4), .alu_src(as4),
        .mem_read(mr4), .mem_write(mw4), .branch(br4), .jump(jp4),
        .illegal(il4), .inst_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic [31:0] imm;
        logic [3:0]  aop;
        logic        rw, rdst, asrc, mr, mw, br, jp, ill;
    } want_t;

    want_t       want;
    int unsigned ecnt16, ecnt4;
    int          n_assert, n_fail;

    // Reference: what the instruction means, taken straight from the decode table.
    function automatic want_t ref_decode(input logic [31:0] w);
        want_t      e;
        logic [15:0] i16;
        logic [4:0]  dst;
        e     = '0;
        e.v   = 1'b1;
        e.ins = w;
        i16   = w[15:0];
        e.imm = {{16{i16[15]}}, i16};
        case (w[31:26])
            6'h00: begin
                e.rdst = 1'b1; e.rw = 1'b1;
                case (w[5:0])
                    6'h20: e.aop = 4'd0;
                    6'h22: e.aop = 4'd1;
                    6'h24: e.aop = 4'd2;
                    6'h25: e.aop = 4'd3;
                    6'h2A: e.aop = 4'd4;
                    6'h00: e.aop = 4'd5;
                    6'h02: e.aop = 4'd6;
                    default: e.ill = 1'b1;
                endcase
            end
            6'h08: begin e.asrc = 1'b1; e.rw = 1'b1; end
            6'h0C: begin e.aop = 4'd2; e.asrc = 1'b1; e.rw = 1'b1; e.imm = {16'h0, i16}; end
            6'h0D: begin e.aop = 4'd3; e.asrc = 1'b1; e.rw = 1'b1; e.imm = {16'h0, i16}; end
            6'h0F: begin e.aop = 4'd7; e.asrc = 1'b1; e.rw = 1'b1; e.imm = {i16, 16'h0}; end
            6'h23: begin e.asrc = 1'b1; e.mr = 1'b1; e.rw = 1'b1; end
            6'h2B: begin e.asrc = 1'b1; e.mw = 1'b1; end
            6'h04, 6'h05: begin e.aop = 4'd1; e.br = 1'b1; end
            6'h02: e.jp = 1'b1;
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin e.aop = 4'd0; e.rw = 1'b0; e.rdst = 1'b0; end
        dst = e.rdst ? w[15:11] : w[20:16];
        if (dst == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".id_valid"},  32'(id_valid),  32'(want.v));
        chk({tag, ".opcode"},    32'(opcode),    32'(want.ins[31:26]));
        chk({tag, ".rs"},        32'(rs),        32'(want.ins[25:21]));
        chk({tag, ".rt"},        32'(rt),        32'(want.ins[20:16]));
        chk({tag, ".rd"},        32'(rd),        32'(want.ins[15:11]));
        chk({tag, ".shamt"},     32'(shamt),     32'(want.ins[10:6]));
        chk({tag, ".funct"},     32'(funct),     32'(want.ins[5:0]));
        chk({tag, ".jaddr"},     32'(jaddr),     32'(want.ins[25:0]));
        chk({tag, ".imm_ext"},   imm_ext,        want.imm);
        chk({tag, ".alu_op"},    32'(alu_op),    32'(want.aop));
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(want.rw));
        chk({tag, ".reg_dst"},   32'(reg_dst),   32'(want.rdst));
        chk({tag, ".alu_src"},   32'(alu_src),   32'(want.asrc));
        chk({tag, ".mem_read"},  32'(mem_read),  32'(want.mr));
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(want.mw));
        chk({tag, ".branch"},    32'(branch),    32'(want.br));
        chk({tag, ".jump"},      32'(jump),      32'(want.jp));
        chk({tag, ".illegal"},   32'(illegal),   32'(want.ill));
        chk({tag, ".inst_cnt"},  32'(inst_cnt),  ecnt16);
        chk({tag, ".cnt4"},      32'(cnt4),      ecnt4);
        chk({tag, ".v4"},        32'(v4),        32'(want.v));
    endtask

    // Advances the model by one edge using the inputs the DUT sees at that edge.
    task automatic model_tick();
        if (flush) want = '0;
        else if (!stall) begin
            if (inst_valid) begin
                want = ref_decode(inst_code);
                if (ecnt16 < 65535) ecnt16++;
                if (ecnt4 < 15) ecnt4++;
            end else want = '0;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_tick();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [31:0] w, input logic v, input logic s, input logic f);
        inst_code  = w;
        inst_valid = v;
        stall      = s;
        flush      = f;
    endtask

    task automatic reset_now();
        rst    = 1'b0;
        want   = '0;
        ecnt16 = 0;
        ecnt4  = 0;
    endtask

    logic [5:0] ops [11];
    logic [5:0] fns [8];

    initial begin
        n_assert = 0; n_fail = 0;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};
        reset_now();
        drive($urandom, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_all("reset");

        rst = 1'b1;
        drive(32'h20080005, 1'b1, 1'b0, 1'b0); step("addi");
        chk("addi.rt_lit", 32'(rt), 32'd8);
        chk("addi.imm_lit", imm_ext, 32'h5);
        chk("addi.cnt_lit", 32'(inst_cnt), 32'd1);
        drive(32'h2108FFFF, 1'b1, 1'b0, 1'b0); step("addi_neg");
        chk("addi_neg.imm_lit", imm_ext, 32'hFFFFFFFF);
        drive(32'h3508FFFF, 1'b1, 1'b0, 1'b0); step("ori");
        chk("ori.imm_lit", imm_ext, 32'h0000FFFF);
        chk("ori.alu_lit", 32'(alu_op), 32'd3);
        drive(32'h3C081234, 1'b1, 1'b0, 1'b0); step("lui");
        chk("lui.imm_lit", imm_ext, 32'h12340000);
        drive(32'h01095020, 1'b1, 1'b0, 1'b0); step("add");
        chk("add.rd_lit", 32'(rd), 32'd10);
        drive(32'h8D0A0004, 1'b1, 1'b0, 1'b0); step("lw");
        chk("lw.mr_lit", 32'(mem_read), 32'd1);
        drive(32'hAD0A0004, 1'b1, 1'b0, 1'b0); step("sw");
        chk("sw.rw_lit", 32'(reg_write), 32'd0);
        drive(32'h08000010, 1'b1, 1'b0, 1'b0); step("j");
        chk("j.jaddr_lit", 32'(jaddr), 32'h10);
        drive(32'h00000000, 1'b1, 1'b0, 1'b0); step("nop");
        chk("nop.rw_lit", 32'(reg_write), 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'b1, 1'b1, 1'b0); step("stall");
        end
        chk("stall.cnt_lit", 32'(inst_cnt), 32'd9);
        drive(32'h20080005, 1'b1, 1'b1, 1'b1); step("stall_flush");
        chk("stall_flush.v_lit", 32'(id_valid), 32'd0);

        drive(32'hFC000000, 1'b1, 1'b0, 1'b0); step("ill_op");
        chk("ill_op.cnt_lit", 32'(inst_cnt), 32'd10);
        drive(32'h0000003F, 1'b1, 1'b0, 1'b0); step("ill_fn");
        chk("ill_fn.ill_lit", 32'(illegal), 32'd1);
        drive(32'h20080005, 1'b0, 1'b0, 1'b0); step("bubble");

        drive(32'h01095020, 1'b1, 1'b0, 1'b0); step("pre_stall");
        drive(32'h8D0A0004, 1'b1, 1'b1, 1'b0);
        #2 reset_now();
        #1 check_all("rst_mid_stall");
        @(posedge clk); #1;
        rst = 1'b1;
        drive(32'h20080005, 1'b1, 1'b0, 1'b0); step("after_rst");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[31:26] = ops[$urandom_range(0, 10)];
            if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 7)];
            drive(w, ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0));
            step("rand");
        end

        #2 reset_now();
        #1 check_all("sat_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(32'h20080005 + i, 1'b1, 1'b0, 1'b0); step("sat");
        end
        chk("sat.cnt4_lit", 32'(cnt4), 32'd15);
        chk("sat.cnt16_lit", 32'(inst_cnt), 32'd20);
        #2 reset_now();
        #1;
        chk("sat.cnt4_async", 32'(cnt4), 32'd0);
        chk("sat.cnt16_async", 32'(inst_cnt), 32'd0);
        check_all("final_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
